if_id_skid_reg: RTL and testbench

- Parametrised, elastic IF/ID pipeline boundary register for the CPU pipeline.
- Replaces the fixed 32-bit stall/flush register with a 2-entry skid buffer using a valid/ready handshake.
- Adds a bubble (NOP) output, occupancy reporting and a flush counter.
- Sits between the fetch stage (PC + instruction memory) and decode (register file / hazard unit).

---
 rtl/if_id_skid_reg.sv | 120 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID boundary register: 2-entry skid buffer with valid/ready handshake,
// bubble (NOP) output, occupancy report and saturating flush counter.
module if_id_skid_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [1:0]         occupancy_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    // Encoding is {s_valid, m_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [INSTR_W-1:0] m_instr_q, m_instr_d;
    logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic m_valid, s_valid, accept, drain;

    assign m_valid = state_q[0];
    assign s_valid = state_q[1];
    assign accept  = in_valid_i & in_ready_o;
    assign drain   = m_valid & out_ready_i;

    always_comb begin
        state_d     = state_q;
        m_addr_d    = m_addr_q;
        m_instr_d   = m_instr_q;
        s_addr_d    = s_addr_q;
        s_instr_d   = s_instr_q;
        flush_cnt_d = flush_cnt_q;

        if (flush_i) begin
            state_d = StEmpty;
            if (in_valid_i) begin
                m_addr_d = addr_i;
            end
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        m_addr_d  = addr_i;
                        m_instr_d = instr_i;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        m_addr_d  = addr_i;
                        m_instr_d = instr_i;
                    end else if (accept) begin
                        s_addr_d  = addr_i;
                        s_instr_d = instr_i;
                        state_d   = StFull;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        m_addr_d  = s_addr_q;
                        m_instr_d = s_instr_q;
                        state_d   = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Pipeline registers in this CPU update on the falling edge.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            m_addr_q    <= '0;
            m_instr_q   <= NOP_INSTR;
            s_addr_q    <= '0;
            s_instr_q   <= NOP_INSTR;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_addr_q    <= m_addr_d;
            m_instr_q   <= m_instr_d;
            s_addr_q    <= s_addr_d;
            s_instr_q   <= s_instr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready_o  = ~s_valid;
    assign out_valid_o = m_valid;
    assign addr_o      = m_addr_q;
    assign instr_o     = m_valid ? m_instr_q : NOP_INSTR;
    assign occupancy_o = {1'b0, m_valid} + {1'b0, s_valid};
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed vector bench for if_id_skid_reg; a second instance with a 2-bit flush
// counter shares the stimulus to exercise saturation.
module tb_if_id_skid_reg;

    localparam logic [31:0] I0 = 32'h2002_0005;
    localparam logic [31:0] I1 = 32'h0085_1020;
    localparam logic [31:0] I2 = 32'h8C03_0000;
    localparam int NV = 17;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic        flush;
        logic        out_ready;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        e_out_valid;
        logic        e_in_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [7:0]  e_cnt;
    } vec_t;

    logic        clk = 1'b1;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] addr, instr;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] addr_o, instr_o, addr_o2, instr_o2;
    logic [1:0]  occ, occ2;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    if_id_skid_reg #(.ADDR_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .addr_i(addr), .instr_i(instr), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .addr_o(addr_o), .instr_o(instr_o),
        .occupancy_o(occ), .flush_cnt_o(cnt)
    );

    if_id_skid_reg #(.ADDR_W(32), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .addr_i(addr), .instr_i(instr), .flush_i(flush), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .addr_o(addr_o2), .instr_o(instr_o2),
        .occupancy_o(occ2), .flush_cnt_o(cnt2)
    );

    function automatic vec_t mk(logic r, logic iv, logic fl, logic ordy, logic [31:0] a,
                                logic [31:0] ins, logic eov, logic eir, logic [1:0] eocc,
                                logic [31:0] ea, logic [31:0] ei, logic [7:0] ec);
        vec_t v;
        v.rst = r; v.in_valid = iv; v.flush = fl; v.out_ready = ordy;
        v.addr = a; v.instr = ins;
        v.e_out_valid = eov; v.e_in_ready = eir; v.e_occ = eocc;
        v.e_addr = ea; v.e_instr = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic fl, input logic ordy,
                         input logic [31:0] a, input logic [31:0] ins);
        rst = r; in_valid = iv; flush = fl; out_ready = ordy; addr = a; instr = ins;
        @(negedge clk);
        #2;
    endtask

    initial begin
        //              rst iv fl ordy addr   instr  ov ir occ e_addr  e_instr cnt
        vecs[0]  = mk(1, 0, 0, 1, 32'h0,  32'h0, 0, 1, 0, 32'h0,  32'h0, 0);
        vecs[1]  = mk(1, 0, 0, 1, 32'h0,  32'h0, 0, 1, 0, 32'h0,  32'h0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h0,  32'h0, 0, 1, 0, 32'h0,  32'h0, 0);
        // streaming at one beat per cycle
        vecs[3]  = mk(0, 1, 0, 1, 32'h4,  I0,    1, 1, 1, 32'h4,  I0,    0);
        vecs[4]  = mk(0, 1, 0, 1, 32'h8,  I1,    1, 1, 1, 32'h8,  I1,    0);
        vecs[5]  = mk(0, 1, 0, 1, 32'hC,  I2,    1, 1, 1, 32'hC,  I2,    0);
        vecs[6]  = mk(0, 0, 0, 1, 32'h0,  32'h0, 0, 1, 0, 32'hC,  32'h0, 0);
        // stall, skid absorb, refused beat, release
        vecs[7]  = mk(0, 1, 0, 0, 32'h4,  I0,    1, 1, 1, 32'h4,  I0,    0);
        vecs[8]  = mk(0, 1, 0, 0, 32'h8,  I1,    1, 0, 2, 32'h4,  I0,    0);
        vecs[9]  = mk(0, 1, 0, 0, 32'hC,  I2,    1, 0, 2, 32'h4,  I0,    0);
        vecs[10] = mk(0, 1, 0, 1, 32'hC,  I2,    1, 1, 1, 32'h8,  I1,    0);
        vecs[11] = mk(0, 1, 0, 1, 32'hC,  I2,    1, 1, 1, 32'hC,  I2,    0);
        // fill to FULL, then flush with an incoming beat
        vecs[12] = mk(0, 1, 0, 0, 32'h10, I0,    1, 0, 2, 32'hC,  I2,    0);
        vecs[13] = mk(0, 1, 1, 0, 32'h40, I1,    0, 1, 0, 32'h40, 32'h0, 1);
        vecs[14] = mk(0, 0, 1, 1, 32'h0,  32'h0, 0, 1, 0, 32'h40, 32'h0, 2);
        vecs[15] = mk(0, 1, 1, 1, 32'h44, I2,    0, 1, 0, 32'h44, 32'h0, 3);
        vecs[16] = mk(0, 1, 0, 1, 32'h48, I2,    1, 1, 1, 32'h48, I2,    3);

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        addr = '0; instr = '0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].in_valid, vecs[i].flush, vecs[i].out_ready,
                  vecs[i].addr, vecs[i].instr);
            check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_out_valid});
            check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_in_ready});
            check($sformatf("v%0d occupancy", i), {30'b0, occ}, {30'b0, vecs[i].e_occ});
            check($sformatf("v%0d addr", i), addr_o, vecs[i].e_addr);
            check($sformatf("v%0d instr", i), instr_o, vecs[i].e_instr);
            check($sformatf("v%0d flush_cnt", i), {24'b0, cnt}, {24'b0, vecs[i].e_cnt});
            check($sformatf("v%0d flush_cnt2", i), {30'b0, cnt2},
                  (vecs[i].e_cnt > 8'd3) ? 32'd3 : {24'b0, vecs[i].e_cnt});
        end

        // Two more flushes: 8-bit counter reaches 5, 2-bit counter stays at 3.
        drive(0, 0, 1, 1, 32'h0, 32'h0);
        drive(0, 0, 1, 1, 32'h0, 32'h0);
        check("sat flush_cnt", {24'b0, cnt}, 32'd5);
        check("sat flush_cnt2", {30'b0, cnt2}, 32'd3);
        check("sat flush addr held", addr_o, 32'h48);

        // Reset mid-stall with flush and an incoming beat in the same cycle.
        drive(0, 1, 0, 0, 32'h50, I0);
        drive(0, 1, 0, 0, 32'h54, I1);
        check("full occupancy", {30'b0, occ}, 32'd2);
        check("full in_ready", {31'b0, in_ready}, 32'd0);
        check("full addr", addr_o, 32'h50);
        drive(1, 1, 1, 0, 32'h60, I2);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst occupancy", {30'b0, occ}, 32'd0);
        check("rst addr", addr_o, 32'h0);
        check("rst instr", instr_o, 32'h0);
        check("rst flush_cnt", {24'b0, cnt}, 32'd0);
        check("rst flush_cnt2", {30'b0, cnt2}, 32'd0);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        check("post-rst occupancy", {30'b0, occ}, 32'd0);
        check("post-rst out_valid", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
